// File: rtl/stream_rr_mux_pkg.sv
// Shared definitions for stream_rr_mux: lock-state encoding and cyclic index helper.
package stream_rr_mux_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  function automatic int unsigned wrap_inc(
    input int unsigned idx,
    input int unsigned n
  );
    if (idx + 1 >= n) return 0;
    return idx + 1;
  endfunction

endpackage

// File: rtl/stream_rr_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester scanning cyclically from ptr.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant
);

  localparam logic [SEL_W:0] NW = (SEL_W+1)'(N);

  logic [SEL_W:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (SEL_W+1)'(k);
      if (idx >= NW) idx = idx - NW;
      if (!grant_valid && req[idx[SEL_W-1:0]]) begin
        grant_valid = 1'b1;
        grant       = idx[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_rr_mux.sv
// N-way round-robin valid/ready stream mux with registered output stage.
// Define STREAM_RR_MUX_LAST_LOCK_EN to hold the grant for a whole packet.
module stream_rr_mux
  import stream_rr_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SEL_W-1:0]   out_sel
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] ptr_nxt;
  logic             gvalid;
  logic [N-1:0]     req;
  logic             load;
  logic             xfer;
  logic             xlast;

  assign load = !out_valid || out_ready;

`ifdef STREAM_RR_MUX_LAST_LOCK_EN
  logic [0:0]       state;
  logic [SEL_W-1:0] lock_idx;

  assign req = (state == ST_LOCK)
             ? (in_valid & (N'(1) << lock_idx))
             : in_valid;
`else
  assign req = in_valid;
`endif

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req         (req),
    .ptr         (ptr),
    .grant_valid (gvalid),
    .grant       (grant)
  );

  // A grant is only ever given to a valid channel, so load+grant is a transfer.
  assign xfer  = resetn && load && gvalid;
  assign xlast = in_last[grant];

  assign in_ready = xfer ? (N'(1) << grant) : '0;

  assign ptr_nxt = SEL_W'(wrap_inc(32'(grant), N));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant*WIDTH +: WIDTH];
      out_last  <= xlast;
      out_sel   <= grant;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_RR_MUX_LAST_LOCK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr      <= '0;
      state    <= ST_IDLE;
      lock_idx <= '0;
    end else if (xfer) begin
      if (xlast) begin
        ptr   <= ptr_nxt;
        state <= ST_IDLE;
      end else if (state == ST_IDLE) begin
        state    <= ST_LOCK;
        lock_idx <= grant;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= ptr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_stream_rr_mux.sv
// Directed self-checking bench for stream_rr_mux (N=4, WIDTH=32).
module tb_stream_rr_mux;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic               clk;
  logic               resetn;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [SEL_W-1:0]   out_sel;

  int vectors;
  int miscompares;

  stream_rr_mux #(
    .WIDTH (WIDTH),
    .N     (N)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] v);
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    in_valid  = 4'b1111;
    in_last   = '1;
    out_ready = 1'b1;
    for (int c = 0; c < N; c++) set_data(c, 32'hAAAA_0000 + c);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
    end
    in_valid = '0;
    resetn   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0 || out_data !== '0 ||
          out_sel !== '0 || out_last !== 1'b0 ||
          in_ready !== '0) begin
        miscompares++;
        $display("FAIL idle_%0d v=%b d=%h s=%0d l=%b r=%b exp 0",
                 k, out_valid, out_data, out_sel, out_last, in_ready);
      end
    end
  endtask

  task automatic test_fairness();
    logic [SEL_W-1:0] exp_sel [6];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    for (int c = 0; c < N; c++) set_data(c, 32'hC0DE_0000 + c);
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_sel !== exp_sel[k] ||
          out_data !== 32'hC0DE_0000 + 32'(exp_sel[k])) begin
        miscompares++;
        $display("FAIL fair_%0d v=%b s=%0d d=%h exp v=1 s=%0d",
                 k, out_valid, out_sel, out_data, exp_sel[k]);
      end
    end
    in_valid = '0;
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fair_drain v=%b exp=0", out_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    in_last  = 4'b1111;
    for (int c = 0; c < N; c++) set_data(c, 32'h5000_0000 + c);
    in_valid = 4'b0100;
    #1;
    vectors++;
    if (in_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL wrap_rdy2 got=%b exp=0100", in_ready);
    end
    step();
    in_valid = 4'b1001;
    #1;
    vectors++;
    if (in_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL wrap_rdy3 got=%b exp=1000", in_ready);
    end
    step();
    vectors++;
    if (out_sel !== 2'd3 || out_data !== 32'h5000_0003) begin
      miscompares++;
      $display("FAIL wrap_sel3 s=%0d d=%h exp s=3", out_sel, out_data);
    end
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_rdy0 got=%b exp=0001", in_ready);
    end
    step();
    vectors++;
    if (out_sel !== 2'd0 || out_data !== 32'h5000_0000) begin
      miscompares++;
      $display("FAIL wrap_sel0 s=%0d d=%h exp s=0", out_sel, out_data);
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    in_last  = 4'b1111;
    in_valid = 4'b0010;
    set_data(1, 32'hBEEF_0001);
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1 ||
        out_data !== 32'hBEEF_0001) begin
      miscompares++;
      $display("FAIL bp_first v=%b s=%0d d=%h exp v=1 s=1",
               out_valid, out_sel, out_data);
    end
    out_ready = 1'b0;
    in_valid  = 4'b0011;
    set_data(0, 32'hBEEF_0010);
    set_data(1, 32'hBEEF_0011);
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (in_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_rdy_%0d got=%b exp=0000", k, in_ready);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 ||
          out_data !== 32'hBEEF_0001) begin
        miscompares++;
        $display("FAIL bp_hold_%0d v=%b s=%0d d=%h exp v=1 s=1",
                 k, out_valid, out_sel, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_release_rdy got=%b exp=0001", in_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 ||
        out_data !== 32'hBEEF_0010) begin
      miscompares++;
      $display("FAIL bp_reload v=%b s=%0d d=%h exp v=1 s=0",
               out_valid, out_sel, out_data);
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_lock();
    logic [SEL_W-1:0] exp_sel [4];
    logic             exp_last [4];
    int               b;
    logic             took1;
`ifdef STREAM_RR_MUX_LAST_LOCK_EN
    exp_sel  = '{2'd1, 2'd1, 2'd1, 2'd2};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_sel  = '{2'd1, 2'd2, 2'd1, 2'd2};
    exp_last = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    b        = 0;
    in_valid = 4'b0110;
    set_data(2, 32'h2222_2222);
    for (int k = 0; k < 4; k++) begin
      in_last = {1'b0, 1'b1, (b == 2), 1'b0};
      set_data(1, 32'h1111_0000 + 32'(b));
      #1;
      took1 = in_ready[1];
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_sel !== exp_sel[k] ||
          out_last !== exp_last[k]) begin
        miscompares++;
        $display("FAIL lock_%0d v=%b s=%0d l=%b exp s=%0d l=%b",
                 k, out_valid, out_sel, out_last, exp_sel[k], exp_last[k]);
      end
      if (took1) b++;
    end
    in_valid = '0;
    step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_valid = 4'b0100;
    in_last  = 4'b0000;
    for (int c = 0; c < N; c++) set_data(c, 32'h7700_0000 + c);
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_sel !== 2'd2) begin
        miscompares++;
        $display("FAIL mid_beat_%0d v=%b s=%0d exp v=1 s=2",
                 k, out_valid, out_sel);
      end
    end
    in_valid = 4'b1111;
    resetn   = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_rst v=%b r=%b exp v=0 r=0000",
               out_valid, in_ready);
    end
    step();
    resetn = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 ||
        out_data !== 32'h7700_0000) begin
      miscompares++;
      $display("FAIL mid_regrant v=%b s=%0d d=%h exp v=1 s=0",
               out_valid, out_sel, out_data);
    end
    in_valid = '0;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    in_valid    = '0;
    in_last     = '0;
    in_data     = '0;
    out_ready   = 1'b0;
    test_reset();
    test_fairness();
    test_wrap();
    test_backpressure();
    test_lock();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
